// File: rtl/mod997_pkg.sv
// Shared constants and FSM state type for the sequential X mod 997 engine.
package mod997_pkg;

    localparam int unsigned W      = 500;
    localparam int unsigned CHUNK  = 10;
    localparam int unsigned NCHUNK = 50;
    localparam int unsigned M      = 997;
    localparam int unsigned K      = 27;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mod_997_step.sv
// One Horner step: (r * 2^10 + c) mod 997 using two folds of 2^10 == 27
// and a single conditional subtract.
module mod_997_step
    import mod997_pkg::*;
(
    input  logic [CHUNK-1:0] r,
    input  logic [CHUNK-1:0] c,
    output logic [CHUNK-1:0] s
);

    localparam int unsigned T_W = 15;
    localparam int unsigned U_W = 11;

    logic [T_W-1:0] w_t;
    logic [U_W-1:0] w_u;
    logic [U_W-1:0] w_v;

    // t <= 27915, u <= 1860, v <= 1050, so one subtract of M lands below M
    always_comb begin
        w_t = T_W'(r) * T_W'(K) + T_W'(c);
        w_u = U_W'(w_t[CHUNK-1:0]) + U_W'(w_t[T_W-1:CHUNK]) * U_W'(K);
        w_v = U_W'(w_u[CHUNK-1:0]) + (w_u[U_W-1] ? U_W'(K) : U_W'(0));
        s   = (w_v >= U_W'(M)) ? CHUNK'(w_v - U_W'(M)) : CHUNK'(w_v);
    end

endmodule

// File: rtl/x_500_mod_997_seq.sv
// Area-optimised 500-bit X mod 997: one 10-bit chunk per cycle, MSB first,
// behind a valid/ready stream interface.
module x_500_mod_997_seq
    import mod997_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     X,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CHUNK-1:0] R,
    output logic             busy
);

    state_t             r_state;
    state_t             w_next_state;
    logic [W-1:0]       r_sr;
    logic [CHUNK-1:0]   r_acc;
    logic [CHUNK-1:0]   w_step;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic               r_busy;
    logic               w_accept;
    logic               w_out_valid_d;
    logic               w_busy_d;

    mod_997_step u_step (
        .r (r_acc),
        .c (r_sr[W-1 -: CHUNK]),
        .s (w_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next_state = RUN;
            RUN:  if (r_cnt == '0) w_next_state = DONE;
            DONE: if (out_ready) w_next_state = in_valid ? RUN : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // in_ready is combinational so DONE can hand off and accept on one edge
    always_comb begin
        in_ready      = !rst && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
        w_accept      = in_valid && in_ready;
        w_out_valid_d = (w_next_state == DONE);
        w_busy_d      = (w_next_state == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_out_valid <= w_out_valid_d;
            r_busy      <= w_busy_d;
            if (w_accept) begin
                r_sr  <= X;
                r_acc <= '0;
                r_cnt <= CNT_W'(NCHUNK - 1);
            end else if (r_state == RUN) begin
                r_acc <= w_step;
                r_sr  <= {r_sr[W-CHUNK-1:0], CHUNK'(0)};
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end else if ((r_state == DONE) && out_ready) begin
                // residue consumed with nothing queued: R reads 0 in IDLE
                r_acc <= '0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign R         = r_acc;
    assign busy      = r_busy;

endmodule

// File: tb/tb_x_500_mod_997_seq.sv
// Scoreboard bench for x_500_mod_997_seq: driver pushes expected residues on
// accept, a negedge monitor pops and compares when a residue is consumed.
module tb_x_500_mod_997_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [499:0] X;
    logic         out_valid;
    logic         out_ready;
    logic [9:0]   R;
    logic         busy;

    typedef struct {
        logic [9:0]  r;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic        prev_ov = 1'b0;
    logic        prev_taken = 1'b0;
    logic [9:0]  prev_r = '0;

    x_500_mod_997_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bitwise long division: the plain definition of X mod 997
    function automatic logic [9:0] ref_mod(input logic [499:0] x);
        int unsigned r = 0;
        for (int i = 499; i >= 0; i--) r = (r * 2 + 32'(x[i])) % 997;
        return 10'(r);
    endfunction

    function automatic logic [499:0] rnd500();
        logic [511:0] t;
        for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
        return t[499:0];
    endfunction

    // Output monitor: protocol invariants, latency, hold under backpressure, residue
    always @(negedge clk) begin
        if (rst) begin
            prev_ov <= 1'b0;
        end else begin
            if (busy) begin
                chk("run_in_ready", 32'(in_ready), 0);
                chk("run_out_valid", 32'(out_valid), 0);
            end
            if (!busy && !out_valid) chk("idle_R", 32'(R), 0);
            if (out_valid && !out_ready) chk("bp_in_ready", 32'(in_ready), 0);
            if (prev_ov && !prev_taken) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_R", 32'(R), 32'(prev_r));
            end
            if (out_valid && !prev_ov) begin
                if (q.size() == 0) chk("unexpected_result", 1, 0);
                else chk("latency", int'(cyc), int'(q[0].cyc + 50));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_take", 1, 0);
                end else begin
                    chk("residue", 32'(R), 32'(q[0].r));
                    q.delete(0);
                end
            end
            prev_ov    <= out_valid;
            prev_taken <= out_ready;
            prev_r     <= R;
        end
    end

    // exp < 0 selects the reference model
    task automatic send(input logic [499:0] x, input int exp);
        int n = 0;
        logic [9:0] e;
        e = (exp < 0) ? ref_mod(x) : 10'(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        X = x;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        q.push_back('{e, cyc + 1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        X = rnd500();
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 0, 1);
    endtask

    task automatic wait_ov();
        int n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("out_valid_timeout", 0, 1);
    endtask

    initial begin
        int unsigned last_a;
        int          nb;
        logic [499:0] v;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        X = '0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_R", 32'(R), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 1);

        // Directed values with known residues
        send(500'd0, 0);          drain();
        send(500'd996, 996);      drain();
        send(500'd997, 0);        drain();
        send(500'd1023, 26);      drain();
        send(500'd1024, 27);      drain();
        v = '0; v[20] = 1'b1;
        send(v, 729);             drain();
        v = '0; v[30] = 1'b1;
        send(v, 740);             drain();
        v = '1;
        send(v, -1);              drain();

        // Backpressure: hold result, ignore in_valid pulses
        out_ready = 1'b0;
        send(rnd500(), -1);
        wait_ov();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            in_valid = i[0];
            X = rnd500();
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Back-to-back with in_valid and out_ready held high
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        X = 500'd1024;
        last_a = 0;
        for (int i = 0; i < 8; i++) begin
            nb = 0;
            while (!in_ready && nb < 200) begin
                @(negedge clk);
                nb++;
            end
            if (nb == 0) @(negedge clk);
            if (!in_ready) begin
                chk("b2b_timeout", 0, 1);
                break;
            end
            q.push_back('{(i % 2 == 0) ? 10'd27 : 10'd0, cyc + 1});
            if (i > 0) chk("b2b_period", int'(cyc + 1 - last_a), 51);
            last_a = cyc + 1;
            @(posedge clk);
            #1;
            X = (i % 2 == 0) ? 500'd997 : 500'd1024;
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();

        // Reset at edge 25 of RUN discards the operand
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        X = rnd500();
        @(negedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (24) @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_R", 32'(R), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_in_ready", 32'(in_ready), 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(500'd1024, 27);
        drain();

        // Reset while holding a finished residue
        out_ready = 1'b0;
        send(rnd500(), -1);
        wait_ov();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("done_rst_out_valid", 32'(out_valid), 0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("done_rst_idle_ready", 32'(in_ready), 1);
        chk("done_rst_busy", 32'(busy), 0);
        chk("done_rst_valid", 32'(out_valid), 0);
        out_ready = 1'b1;

        // Random operands against the reference model
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(rnd500(), -1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
